// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate-left/right, bounce and blink-all stepped by a speed-selected tick.
// led and tick are registered together so every pattern step coincides with a one-cycle tick.
module led_pattern_gen #(
  parameter int N_LED    = 4,
  parameter int CLK_HZ   = 5_000_000,
  parameter int STEP_MS0 = 200,
  parameter int STEP_MS1 = 350,
  parameter int STEP_MS2 = 500,
  parameter int STEP_MS3 = 1000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam int unsigned RELOAD0 = CLK_HZ / 1000 * STEP_MS0;
  localparam int unsigned RELOAD1 = CLK_HZ / 1000 * STEP_MS1;
  localparam int unsigned RELOAD2 = CLK_HZ / 1000 * STEP_MS2;
  localparam int unsigned RELOAD3 = CLK_HZ / 1000 * STEP_MS3;
  localparam int unsigned RMAX01  = (RELOAD0 > RELOAD1) ? RELOAD0 : RELOAD1;
  localparam int unsigned RMAX23  = (RELOAD2 > RELOAD3) ? RELOAD2 : RELOAD3;
  localparam int unsigned RMAX    = (RMAX01 > RMAX23) ? RMAX01 : RMAX23;
  localparam int          CW      = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [CW-1:0]    LAST0    = CW'(RELOAD0 - 1);
  localparam logic [CW-1:0]    LAST1    = CW'(RELOAD1 - 1);
  localparam logic [CW-1:0]    LAST2    = CW'(RELOAD2 - 1);
  localparam logic [CW-1:0]    LAST3    = CW'(RELOAD3 - 1);
  localparam logic [N_LED-1:0] LED_INIT = N_LED'(1);

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [N_LED-1:0] led_q, led_nxt;
  logic             tick_q, tick_nxt;
  dir_t             dir_q, dir_nxt;
  logic [1:0]       prev_mode, prev_speed;

  logic [CW-1:0]    last;
  logic             mode_chg, speed_chg;
  logic [N_LED-1:0] rotl, rotr;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q      <= '0;
      led_q      <= LED_INIT;
      tick_q     <= 1'b0;
      dir_q      <= DIR_UP;
      prev_mode  <= mode;
      prev_speed <= speed;
    end else begin
      cnt_q      <= cnt_nxt;
      led_q      <= led_nxt;
      tick_q     <= tick_nxt;
      dir_q      <= dir_nxt;
      prev_mode  <= mode;
      prev_speed <= speed;
    end
  end

  always_comb begin
    case (speed)
      2'b00:   last = LAST0;
      2'b01:   last = LAST1;
      2'b10:   last = LAST2;
      default: last = LAST3;
    endcase
  end

  assign mode_chg  = (mode != prev_mode);
  assign speed_chg = (speed != prev_speed);

  // Index-based rotates degenerate to a hold when N_LED is 1.
  always_comb begin
    rotl = '0;
    rotr = '0;
    for (int i = 0; i < N_LED; i++) begin
      rotl[i] = led_q[(i + N_LED - 1) % N_LED];
      rotr[i] = led_q[(i + 1) % N_LED];
    end
  end

  // Next-state logic: mode change > speed change > enabled counting.
  always_comb begin
    cnt_nxt  = cnt_q;
    led_nxt  = led_q;
    tick_nxt = 1'b0;
    dir_nxt  = dir_q;
    if (mode_chg) begin
      cnt_nxt = '0;
      led_nxt = (mode == 2'b11) ? '1 : LED_INIT;
      dir_nxt = DIR_UP;
    end else if (speed_chg) begin
      cnt_nxt = '0;
    end else if (enable) begin
      // >= keeps the counter bounded even if it were ever above the reload point
      if (cnt_q >= last) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        case (mode)
          2'b00: led_nxt = rotl;
          2'b01: led_nxt = rotr;
          2'b10: begin
            if (N_LED > 1) begin
              if (dir_q == DIR_UP) begin
                if (led_q[N_LED-1]) begin
                  dir_nxt = DIR_DOWN;
                  led_nxt = led_q >> 1;
                end else begin
                  led_nxt = led_q << 1;
                end
              end else begin
                if (led_q[0]) begin
                  dir_nxt = DIR_UP;
                  led_nxt = led_q << 1;
                end else begin
                  led_nxt = led_q >> 1;
                end
              end
            end
          end
          default: led_nxt = ~led_q;
        endcase
      end else begin
        cnt_nxt = cnt_q + CW'(1);
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    led  = led_q;
    tick = tick_q;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen with RELOAD = 10/20/30/40.
module tb_led_pattern_gen;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [3:0] led;
  logic       tick;

  int total = 0;
  int bad   = 0;

  led_pattern_gen #(
    .N_LED(4), .CLK_HZ(10_000),
    .STEP_MS0(1), .STEP_MS1(2), .STEP_MS2(3), .STEP_MS3(4)
  ) dut (
    .clk_in(clk_in), .rst(rst), .enable(enable),
    .mode(mode), .speed(speed), .led(led), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  // Advance one rising edge; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; mode = 2'b00; speed = 2'b00;
    step(); step();
    total++;
    if (led !== 4'b0001 || tick !== 1'b0) begin
      bad++; $display("FAIL reset_state: led=%b tick=%b want led=0001 tick=0", led, tick);
    end
    rst = 1'b0;
    step();
    total++;
    if (led !== 4'b0001 || tick !== 1'b0) begin
      bad++; $display("FAIL reset_exit: led=%b tick=%b want led=0001 tick=0", led, tick);
    end
  endtask

  task automatic test_rotate_left();
    logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] cur = 4'b0001;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 1; c <= 10; c++) begin
        step();
        total++;
        if (tick !== (c == 10) || led !== ((c == 10) ? seq[k] : cur)) begin
          bad++; $display("FAIL rotl k=%0d c=%0d: led=%b tick=%b want led=%b tick=%0d",
                          k, c, led, tick, (c == 10) ? seq[k] : cur, c == 10);
        end
      end
      cur = seq[k];
    end
  endtask

  task automatic test_mode_change();
    repeat (7) step();
    mode = 2'b11;
    step();
    total++;
    if (led !== 4'b1111 || tick !== 1'b0) begin
      bad++; $display("FAIL mode_to_blink: led=%b tick=%b want led=1111 tick=0", led, tick);
    end
    for (int c = 1; c <= 10; c++) begin
      step();
      total++;
      if (tick !== (c == 10) || led !== ((c == 10) ? 4'b0000 : 4'b1111)) begin
        bad++; $display("FAIL blink c=%0d: led=%b tick=%b", c, led, tick);
      end
    end
    mode = 2'b01;
    step();
    total++;
    if (led !== 4'b0001 || tick !== 1'b0) begin
      bad++; $display("FAIL mode_to_rotr: led=%b tick=%b want led=0001 tick=0", led, tick);
    end
    for (int c = 1; c <= 10; c++) begin
      step();
      total++;
      if (tick !== (c == 10) || led !== ((c == 10) ? 4'b1000 : 4'b0001)) begin
        bad++; $display("FAIL rotr c=%0d: led=%b tick=%b", c, led, tick);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] seq [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                            4'b0010, 4'b0001, 4'b0010, 4'b0100};
    logic [3:0] cur = 4'b0001;
    mode = 2'b10;
    step();
    total++;
    if (led !== 4'b0001 || tick !== 1'b0) begin
      bad++; $display("FAIL bounce_start: led=%b tick=%b want led=0001 tick=0", led, tick);
    end
    for (int k = 0; k < 8; k++) begin
      for (int c = 1; c <= 10; c++) begin
        step();
        total++;
        if (tick !== (c == 10) || led !== ((c == 10) ? seq[k] : cur)) begin
          bad++; $display("FAIL bounce k=%0d c=%0d: led=%b tick=%b want led=%b",
                          k, c, led, tick, (c == 10) ? seq[k] : cur);
        end
      end
      cur = seq[k];
    end
  endtask

  task automatic test_speed_change();
    repeat (5) step();
    speed = 2'b11;
    step();
    total++;
    if (led !== 4'b0100 || tick !== 1'b0) begin
      bad++; $display("FAIL speed_restart: led=%b tick=%b want led=0100 tick=0", led, tick);
    end
    for (int c = 1; c <= 40; c++) begin
      step();
      total++;
      if (tick !== (c == 40) || led !== ((c == 40) ? 4'b1000 : 4'b0100)) begin
        bad++; $display("FAIL speed_slow c=%0d: led=%b tick=%b", c, led, tick);
      end
    end
    // Change speed on the cycle that would otherwise tick.
    repeat (39) step();
    speed = 2'b00;
    step();
    total++;
    if (led !== 4'b1000 || tick !== 1'b0) begin
      bad++; $display("FAIL speed_at_last: led=%b tick=%b want led=1000 tick=0", led, tick);
    end
    for (int c = 1; c <= 10; c++) begin
      step();
      total++;
      if (tick !== (c == 10) || led !== ((c == 10) ? 4'b0100 : 4'b1000)) begin
        bad++; $display("FAIL speed_fast c=%0d: led=%b tick=%b", c, led, tick);
      end
    end
  endtask

  task automatic test_enable();
    repeat (4) step();
    enable = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      step();
      total++;
      if (tick !== 1'b0 || led !== 4'b0100) begin
        bad++; $display("FAIL disabled c=%0d: led=%b tick=%b want led=0100 tick=0", c, led, tick);
      end
    end
    enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      total++;
      if (tick !== (c == 6) || led !== ((c == 6) ? 4'b0010 : 4'b0100)) begin
        bad++; $display("FAIL reenable c=%0d: led=%b tick=%b", c, led, tick);
      end
    end
  endtask

  task automatic test_reset_mid_step();
    mode = 2'b01;
    step();
    repeat (20) step();
    total++;
    if (led !== 4'b0100 || tick !== 1'b1) begin
      bad++; $display("FAIL rotr_setup: led=%b tick=%b want led=0100 tick=1", led, tick);
    end
    repeat (8) step();
    rst = 1'b1;
    step();
    total++;
    if (led !== 4'b0001 || tick !== 1'b0) begin
      bad++; $display("FAIL mid_reset: led=%b tick=%b want led=0001 tick=0", led, tick);
    end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      total++;
      if (tick !== (c == 10) || led !== ((c == 10) ? 4'b1000 : 4'b0001)) begin
        bad++; $display("FAIL after_reset c=%0d: led=%b tick=%b", c, led, tick);
      end
    end
  endtask

  initial begin
    @(negedge clk_in);
    test_reset();
    test_rotate_left();
    test_mode_change();
    test_bounce();
    test_speed_change();
    test_enable();
    test_reset_mid_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
